// File: rtl/uart_rx.sv
// UART receiver: 16x oversampled start/data/parity/stop decode with a valid/ready character port.
// Error flags travel with the held character; overrun pulses when a finished character is dropped.
module uart_rx #(
  parameter int unsigned DATA_BITS  = 8,
  parameter bit          PARITY_EN  = 1'b0,
  parameter bit          PARITY_ODD = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 sample_tick,
  input  logic                 rx_i,
  output logic [DATA_BITS-1:0] rx_data_o,
  output logic                 rx_valid_o,
  input  logic                 rx_ready_i,
  output logic                 frame_err_o,
  output logic                 parity_err_o,
  output logic                 overrun_o,
  output logic                 busy_o
);

  localparam int unsigned BitCntW = $clog2(DATA_BITS + 1);

  typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;

  state_e               state_q, state_d;
  logic [3:0]           tick_cnt_q, tick_cnt_d;
  logic [BitCntW-1:0]   bit_cnt_q, bit_cnt_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 par_bit_q, par_bit_d;
  logic                 rx_meta_q, rx_s_q;
  logic                 complete;

  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 ferr_q, ferr_d;
  logic                 perr_q, perr_d;
  logic                 ovr_q, ovr_d;

  always_comb begin
    state_d    = state_q;
    tick_cnt_d = tick_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    par_bit_d  = par_bit_q;
    complete   = 1'b0;
    if (sample_tick) begin
      unique case (state_q)
        StIdle: begin
          if (!rx_s_q) begin
            state_d    = StStart;
            tick_cnt_d = '0;
          end
        end
        StStart: begin
          if (tick_cnt_q == 4'd7) begin
            // Start bit must still be low at its midpoint, otherwise treat as a glitch
            if (!rx_s_q) begin
              state_d    = StData;
              tick_cnt_d = '0;
              bit_cnt_d  = '0;
            end else begin
              state_d = StIdle;
            end
          end else begin
            tick_cnt_d = tick_cnt_q + 4'd1;
          end
        end
        StData: begin
          if (tick_cnt_q == 4'd15) begin
            shift_d    = {rx_s_q, shift_q[DATA_BITS-1:1]};
            bit_cnt_d  = bit_cnt_q + BitCntW'(1);
            tick_cnt_d = '0;
            if (bit_cnt_q == BitCntW'(DATA_BITS - 1)) begin
              state_d = PARITY_EN ? StParity : StStop;
            end
          end else begin
            tick_cnt_d = tick_cnt_q + 4'd1;
          end
        end
        StParity: begin
          if (tick_cnt_q == 4'd15) begin
            par_bit_d  = rx_s_q;
            tick_cnt_d = '0;
            state_d    = StStop;
          end else begin
            tick_cnt_d = tick_cnt_q + 4'd1;
          end
        end
        StStop: begin
          if (tick_cnt_q == 4'd15) begin
            complete   = 1'b1;
            tick_cnt_d = '0;
            state_d    = StIdle;
          end else begin
            tick_cnt_d = tick_cnt_q + 4'd1;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    ferr_d  = ferr_q;
    perr_d  = perr_q;
    ovr_d   = 1'b0;
    if (valid_q && rx_ready_i) begin
      valid_d = 1'b0;
    end
    if (complete) begin
      if (!valid_q || rx_ready_i) begin
        data_d  = shift_q;
        ferr_d  = !rx_s_q;
        perr_d  = PARITY_EN & (^shift_q ^ par_bit_q ^ PARITY_ODD);
        valid_d = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta_q  <= 1'b1;
      rx_s_q     <= 1'b1;
      state_q    <= StIdle;
      tick_cnt_q <= '0;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      par_bit_q  <= 1'b0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      ferr_q     <= 1'b0;
      perr_q     <= 1'b0;
      ovr_q      <= 1'b0;
    end else begin
      rx_meta_q  <= rx_i;
      rx_s_q     <= rx_meta_q;
      state_q    <= state_d;
      tick_cnt_q <= tick_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      par_bit_q  <= par_bit_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      ferr_q     <= ferr_d;
      perr_q     <= perr_d;
      ovr_q      <= ovr_d;
    end
  end

  assign rx_data_o    = data_q;
  assign rx_valid_o   = valid_q;
  assign frame_err_o  = ferr_q;
  assign parity_err_o = perr_q;
  assign overrun_o    = ovr_q;
  assign busy_o       = (state_q != StIdle);

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: an 8N1 and an 8E1 receiver share clock, tick and reset; a frame-level
// model predicts each completion tick and the resulting port state, checked every cycle.
module tb_uart_rx;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       sample_tick = 1'b0;
  logic       rx_line  [2];
  logic       ready    [2];
  logic [7:0] data_o   [2];
  logic       valid_o  [2];
  logic       ferr_o   [2];
  logic       perr_o   [2];
  logic       ovr_o    [2];
  logic       busy_o   [2];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  uart_rx #(.DATA_BITS(8), .PARITY_EN(1'b0), .PARITY_ODD(1'b0)) u_dut_n (
    .clk(clk), .rst(rst), .sample_tick(sample_tick), .rx_i(rx_line[0]),
    .rx_data_o(data_o[0]), .rx_valid_o(valid_o[0]), .rx_ready_i(ready[0]),
    .frame_err_o(ferr_o[0]), .parity_err_o(perr_o[0]), .overrun_o(ovr_o[0]),
    .busy_o(busy_o[0])
  );

  uart_rx #(.DATA_BITS(8), .PARITY_EN(1'b1), .PARITY_ODD(1'b0)) u_dut_e (
    .clk(clk), .rst(rst), .sample_tick(sample_tick), .rx_i(rx_line[1]),
    .rx_data_o(data_o[1]), .rx_valid_o(valid_o[1]), .rx_ready_i(ready[1]),
    .frame_err_o(ferr_o[1]), .parity_err_o(perr_o[1]), .overrun_o(ovr_o[1]),
    .busy_o(busy_o[1])
  );

  // sample_tick: one cycle in every four
  int unsigned ph = 0;
  initial forever begin
    @(posedge clk);
    #1;
    ph = (ph + 1) % 4;
    sample_tick = (ph == 0);
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      if (errors <= 40) $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Frame-level model: completion happens on the tick T0+8+16*(bits after start)
  typedef struct packed {
    int unsigned stop;
    logic        idx;
    logic [7:0]  data;
    logic        ferr;
    logic        perr;
  } frame_t;

  frame_t      pend[$];
  int unsigned ticks = 0;
  logic        m_valid [2];
  logic [7:0]  m_data  [2];
  logic        m_ferr  [2];
  logic        m_perr  [2];
  logic        m_ovr   [2];
  bit          cmp_en = 1'b0;

  initial forever begin
    frame_t f;
    @(posedge clk);
    if (sample_tick) ticks++;
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        m_valid[i] = 1'b0; m_data[i] = 8'h00; m_ferr[i] = 1'b0; m_perr[i] = 1'b0;
        m_ovr[i] = 1'b0;
      end else begin
        m_ovr[i] = 1'b0;
        if (m_valid[i] && ready[i]) m_valid[i] = 1'b0;
      end
    end
    if (rst) begin
      pend.delete();
    end else if (sample_tick) begin
      for (int k = pend.size() - 1; k >= 0; k--) begin
        if (pend[k].stop == ticks) begin
          f = pend[k];
          pend.delete(k);
          if (!m_valid[f.idx]) begin
            m_valid[f.idx] = 1'b1;
            m_data[f.idx]  = f.data;
            m_ferr[f.idx]  = f.ferr;
            m_perr[f.idx]  = f.perr;
          end else begin
            m_ovr[f.idx] = 1'b1;
          end
        end
      end
    end
  end

  // Per-cycle comparison and log of accepted characters {ferr, perr, data}
  logic [9:0] log0[$];
  logic [9:0] log1[$];
  int         ovr_cnt [2] = '{0, 0};

  initial forever begin
    @(negedge clk);
    if (cmp_en) begin
      for (int i = 0; i < 2; i++) begin
        chk($sformatf("valid[%0d]", i), int'(valid_o[i]), int'(m_valid[i]));
        chk($sformatf("overrun[%0d]", i), int'(ovr_o[i]), int'(m_ovr[i]));
        if (m_valid[i]) begin
          chk($sformatf("data[%0d]", i), int'(data_o[i]), int'(m_data[i]));
          chk($sformatf("frame_err[%0d]", i), int'(ferr_o[i]), int'(m_ferr[i]));
          chk($sformatf("parity_err[%0d]", i), int'(perr_o[i]), int'(m_perr[i]));
        end
        if (valid_o[i] === 1'b1 && ready[i]) begin
          if (i == 0) log0.push_back({ferr_o[0], perr_o[0], data_o[0]});
          else        log1.push_back({ferr_o[1], perr_o[1], data_o[1]});
        end
        if (ovr_o[i] === 1'b1) ovr_cnt[i]++;
      end
    end
  end

  task automatic chk_log(input string name, input int which, input int idx, input int exp);
    int act;
    act = -1;
    if (which == 0 && idx < log0.size()) act = int'(log0[idx]);
    if (which == 1 && idx < log1.size()) act = int'(log1[idx]);
    chk(name, act, exp);
  endtask

  task automatic wait_until(input int unsigned t);
    while (ticks < t) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic sync_tick();
    do @(posedge clk); while (!sample_tick);
    #2;
  endtask

  int unsigned sched_stop = 0;

  task automatic send(input int i, input logic [7:0] d, input logic pbit, input logic stopb);
    int unsigned n, nb;
    logic        bits [11];
    frame_t      f;
    sync_tick();
    n = ticks;
    nb = (i == 1) ? 11 : 10;
    bits[0] = 1'b0;
    for (int k = 0; k < 8; k++) bits[k+1] = d[k];
    if (i == 1) begin
      bits[9] = pbit; bits[10] = stopb;
    end else begin
      bits[9] = stopb; bits[10] = 1'b1;
    end
    f.idx  = (i == 1);
    f.stop = n + 1 + 8 + 16 * (nb - 1);
    f.data = d;
    f.ferr = !stopb;
    f.perr = (i == 1) ? (^d ^ pbit) : 1'b0;
    pend.push_back(f);
    sched_stop = f.stop;
    for (int k = 0; k < int'(nb); k++) begin
      rx_line[i] = bits[k];
      wait_until(n + 16 * (k + 1));
    end
    rx_line[i] = 1'b1;
    wait_until(n + 16 * nb + 16);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL timeout: simulation did not finish, errors so far %0d", errors);
    $fatal(1, "timeout");
  end

  initial begin
    int unsigned n;
    rx_line[0] = 1'b1; rx_line[1] = 1'b1;
    ready[0] = 1'b1; ready[1] = 1'b1;
    rst = 1'b1;
    repeat (4) @(posedge clk);
    #2;
    rst = 1'b0;
    cmp_en = 1'b1;
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("rst data[%0d]", i), int'(data_o[i]), 0);
      chk($sformatf("rst valid[%0d]", i), int'(valid_o[i]), 0);
      chk($sformatf("rst ferr[%0d]", i), int'(ferr_o[i]), 0);
      chk($sformatf("rst perr[%0d]", i), int'(perr_o[i]), 0);
      chk($sformatf("rst ovr[%0d]", i), int'(ovr_o[i]), 0);
      chk($sformatf("rst busy[%0d]", i), int'(busy_o[i]), 0);
    end

    // 8N1 basic frame
    send(0, 8'hA5, 1'b0, 1'b1);
    chk("8n1 count", log0.size(), 1);
    chk_log("8n1 A5", 0, 0, 10'h0A5);

    // Glitch: low for 5 ticks only
    sync_tick();
    n = ticks;
    rx_line[0] = 1'b0;
    wait_until(n + 5);
    rx_line[0] = 1'b1;
    wait_until(n + 24);
    chk("glitch count", log0.size(), 1);
    chk("glitch busy", int'(busy_o[0]), 0);
    send(0, 8'h3C, 1'b0, 1'b1);
    chk_log("after glitch 3C", 0, 1, 10'h03C);

    // Even parity
    send(1, 8'h07, 1'b1, 1'b1);
    send(1, 8'h07, 1'b0, 1'b1);
    chk("parity count", log1.size(), 2);
    chk_log("parity ok", 1, 0, 10'h007);
    chk_log("parity bad", 1, 1, 10'h107);

    // Framing error
    send(0, 8'h55, 1'b0, 1'b0);
    chk("frame count", log0.size(), 3);
    chk_log("frame err 55", 0, 2, 10'h255);

    // Backpressure and overrun
    ready[0] = 1'b0;
    send(0, 8'h11, 1'b0, 1'b1);
    send(0, 8'h22, 1'b0, 1'b1);
    chk("ovr pulses", ovr_cnt[0], 1);
    chk("held valid", int'(valid_o[0]), 1);
    chk("held data", int'(data_o[0]), 8'h11);
    ready[0] = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    ready[0] = 1'b0;
    chk("drain count", log0.size(), 4);
    chk_log("drain 11", 0, 3, 10'h011);
    chk("drain valid", int'(valid_o[0]), 0);

    // Ready asserted exactly in the completion cycle of the second character
    send(0, 8'h11, 1'b0, 1'b1);
    sched_stop = 0;
    fork
      send(0, 8'h22, 1'b0, 1'b1);
      begin
        wait (sched_stop != 0);
        wait_until(sched_stop - 1);
        repeat (3) @(posedge clk);
        #2;
        ready[0] = 1'b1;
        @(posedge clk);
        #2;
        ready[0] = 1'b0;
      end
    join
    chk("no ovr", ovr_cnt[0], 1);
    chk("swap valid", int'(valid_o[0]), 1);
    chk("swap data", int'(data_o[0]), 8'h22);
    chk_log("swap 11", 0, 4, 10'h011);
    ready[0] = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    chk("swap count", log0.size(), 6);
    chk_log("swap 22", 0, 5, 10'h022);

    // Reset during data bit 3 of an all-zero frame
    sync_tick();
    n = ticks;
    rx_line[0] = 1'b0;
    wait_until(n + 72);
    chk("midframe busy", int'(busy_o[0]), 1);
    rst = 1'b1;
    rx_line[0] = 1'b1;
    @(posedge clk);
    #2;
    rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("mrst data[%0d]", i), int'(data_o[i]), 0);
      chk($sformatf("mrst valid[%0d]", i), int'(valid_o[i]), 0);
      chk($sformatf("mrst ferr[%0d]", i), int'(ferr_o[i]), 0);
      chk($sformatf("mrst perr[%0d]", i), int'(perr_o[i]), 0);
      chk($sformatf("mrst busy[%0d]", i), int'(busy_o[i]), 0);
    end
    wait_until(ticks + 20);
    send(0, 8'hC3, 1'b0, 1'b1);
    chk("final count", log0.size(), 7);
    chk_log("final C3", 0, 6, 10'h0C3);
    chk("final count e", log1.size(), 2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
# uart_rx

UART receive stage that sits directly downstream of the baud-rate tick generator. It consumes a 16x-oversampling tick pulse and synchronises and decodes the asynchronous serial line (start bit, LSB-first data, optional parity, one stop bit). It presents each received character on a valid/ready output port, with per-character framing and parity error flags and an overrun pulse.

## Interface
- `DATA_BITS`, default 8: data bits per character (5..8).
- `PARITY_EN`, default 0: 1 = one parity bit is expected after the data bits.
- `PARITY_ODD`, default 0: 1 = odd parity, 0 = even; ignored when `PARITY_EN`=0.
- `clk`  in  1  single clock; all logic is on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `sample_tick`  in  1  one-`clk` pulse at 16x the baud rate, from the baud-rate generator.
- `rx_i`  in  1  asynchronous serial line; idles high.
- `rx_data_o`  out  DATA_BITS  received character; bit 0 is the first bit on the line.
- `rx_valid_o`  out  1  character available on `rx_data_o`.
- `rx_ready_i`  in  1  consumer accepts the character when high together with `rx_valid_o`.
- `frame_err_o`  out  1  stop bit was sampled low for the held character.
- `parity_err_o`  out  1  parity mismatch for the held character; always 0 when `PARITY_EN`=0.
- `overrun_o`  out  1  one-cycle pulse: a completed character was dropped.
- `busy_o`  out  1  FSM is not in IDLE.

## Operation
- Synchroniser: two flops on `rx_i`, both reset to 1. All decoding uses the second flop output (`rx_s`) only.
- Counters:
  - `tick_cnt` (4 bit) advances only on cycles with `sample_tick`=1.
  - `bit_cnt` is $clog2(DATA_BITS+1) bits wide.
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE:
  - On a tick with `rx_s`=0: go to START, `tick_cnt`=0.
- START:
  - Ticks increment `tick_cnt`.
  - On the tick where `tick_cnt`==7 (mid start bit): if `rx_s`=0, go to DATA with `tick_cnt`=0 and `bit_cnt`=0.
  - Otherwise return to IDLE as a glitch rejection; no output and no flags.
- DATA:
  - On the tick where `tick_cnt`==15: sample `rx_s` into the shift register MSB, shift right, `bit_cnt`++, `tick_cnt`=0.
  - After `DATA_BITS` samples, go to PARITY if `PARITY_EN`, else STOP.
- PARITY:
  - At `tick_cnt`==15, sample the parity bit and go to STOP.
  - Error condition (even parity): XOR of the data bits and the parity bit must be 0.
  - Error condition (odd parity): that XOR must be 1.
- STOP:
  - At `tick_cnt`==15, sample the stop bit, perform completion, and go to IDLE.
  - The transition to IDLE is the same whether the stop bit is 0 or 1. With a line held low (break), the block therefore receives repeated all-zero characters, each with `frame_err_o`=1.
- Completion:
  - If `rx_valid_o`=0, or the same cycle has `rx_ready_i`=1: load `rx_data_o`, `frame_err_o` (= !stop bit) and `parity_err_o` together, and set `rx_valid_o`=1.
  - Otherwise keep the held character and flags unchanged, discard the new one, and pulse `overrun_o` for 1 cycle.
- Handshake:
  - `rx_valid_o` falls the cycle after `rx_valid_o` & `rx_ready_i`, unless a completion loads in that same cycle.
  - `rx_data_o` and the flags are stable while `rx_valid_o`=1 and not accepted.
- `sample_tick`=0 freezes all counters and the FSM; the synchroniser keeps running.

## Timing
- Reset values:
  - `rx_data_o`=0, `rx_valid_o`=0, `frame_err_o`=0, `parity_err_o`=0, `overrun_o`=0, `busy_o`=0.
  - FSM in IDLE, counters 0, synchroniser 11.
  - Reset in mid-frame aborts the frame with no output.
- Input latency: a change on `rx_i` is visible on `rx_s` 2 `clk` cycles later.
- Sampling points, counted from tick T0 (the tick on which IDLE first sees `rx_s`=0):
  - Start check at T0+8.
  - Data bit k sampled at T0+8+16(k+1).
  - Stop bit sampled at T0+8+16(DATA_BITS+PARITY_EN+1); this is T0+152 for 8N1.
- `rx_valid_o` rises on the `clk` edge immediately after the stop-sample tick cycle. `overrun_o` pulses in that same cycle.
- `busy_o` is high from the cycle after T0 until the cycle after the stop sample.
- A new start bit can be detected on the first tick after returning to IDLE.

## Test plan
- 8N1 reception:
  - Setup: `sample_tick` every 4 clk; send 0xA5 at exactly 16 ticks per bit; `rx_ready_i`=1.
  - Required: `rx_data_o`=0xA5 with one valid cycle and both error flags 0; valid rises 1 cycle after tick T0+152.
- Glitch rejection:
  - Stimulus: pull `rx_i` low for 5 ticks, then high.
  - Required: return to IDLE with no `rx_valid_o`. A following 0x3C frame is received correctly.
- Parity (`PARITY_EN`=1, `PARITY_ODD`=0):
  - Send 0x07 with parity bit 1: `parity_err_o`=0.
  - Send 0x07 with parity bit 0: `parity_err_o`=1 with `rx_data_o`=0x07.
- Framing error:
  - Stimulus: send 0x55 with the stop bit low, then idle high.
  - Required: `rx_data_o`=0x55 and `frame_err_o`=1.
- Backpressure and overrun:
  - Stimulus: `rx_ready_i`=0; send 0x11, then 0x22.
  - Required: 0x11 is held, `overrun_o` pulses once at 0x22 completion, and raising ready delivers 0x11 only.
  - Repeat with ready asserted exactly in the completion cycle of 0x22: 0x22 loads, valid stays 1, no overrun.
- Reset mid-frame:
  - Stimulus: assert `rst` during data bit 3, release, then send 0xC3.
  - Required: outputs are at their reset values after `rst`; 0xC3 is received with no spurious character.
